// File: rtl/dmem_arbiter_if.sv
// Bundle of the IF requester, LS requester and memory-port signals around dmem_arbiter.
// The arbiter uses the slave view; requesters and memory together form the master view.
interface dmem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        if_err;

  logic        ls_req;
  logic        ls_we;
  logic [2:0]  ls_ctr;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic        ls_gnt;
  logic        ls_rvalid;
  logic [31:0] ls_rdata;
  logic        ls_err;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata, if_err,
    input  ls_req, ls_we, ls_ctr, ls_addr, ls_wdata,
    output ls_gnt, ls_rvalid, ls_rdata, ls_err,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rvalid, mem_rdata
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata, if_err,
    output ls_req, ls_we, ls_ctr, ls_addr, ls_wdata,
    input  ls_gnt, ls_rvalid, ls_rdata, ls_err,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and load/store,
// with sub-word lane handling, legality checks and a WAIT-state timeout.
module dmem_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  dmem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t      state_reg, state_next;
  logic        last_ls_reg, last_ls_next;
  logic        owner_ls_reg, owner_ls_next;
  logic        we_reg, we_next;
  logic [2:0]  ctr_reg, ctr_next;
  logic [31:0] addr_reg, addr_next;
  logic [31:0] wdata_reg, wdata_next;
  logic [31:0] rdata_reg, rdata_next;
  logic        err_reg, err_next;
  logic [15:0] cnt_reg, cnt_next;

  logic        if_win, ls_win;
  logic        sel_we;
  logic [2:0]  sel_ctr;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        sel_illegal, sel_misaligned;
  logic [16:0] cnt_inc;
  logic [31:0] lane;
  logic [31:0] load_ext;
  logic [3:0]  lane_strb;
  logic [31:0] shifted_wdata;

  // Grants are only offered in IDLE; ties go to the requester not served last.
  // Gated by rst_n so every output is quiet while reset is held.
  always_comb begin
    if_win = 1'b0;
    ls_win = 1'b0;
    if (rst_n && state_reg == IDLE) begin
      if (bus.if_req && bus.ls_req) begin
        if_win = last_ls_reg;
        ls_win = !last_ls_reg;
      end else begin
        if_win = bus.if_req;
        ls_win = bus.ls_req;
      end
    end
  end

  assign sel_we    = ls_win & bus.ls_we;
  assign sel_ctr   = ls_win ? bus.ls_ctr   : 3'b010;
  assign sel_addr  = ls_win ? bus.ls_addr  : bus.if_addr;
  assign sel_wdata = ls_win ? bus.ls_wdata : 32'h0;

  assign sel_illegal    = (sel_ctr == 3'b011) || (sel_ctr[2:1] == 2'b11) ||
                          (sel_we && sel_ctr[2]);
  assign sel_misaligned = ((sel_ctr[1:0] == 2'b01) && sel_addr[0]) ||
                          ((sel_ctr[1:0] == 2'b10) && (sel_addr[1:0] != 2'b00));

  assign cnt_inc = {1'b0, cnt_reg} + 17'd1;

  // Load path: bring the addressed lane down to bit 0, then extend by size code.
  assign lane = bus.mem_rdata >> {addr_reg[1:0], 3'b000};

  always_comb begin
    case (ctr_reg)
      3'b000:  load_ext = {{24{lane[7]}}, lane[7:0]};
      3'b001:  load_ext = {{16{lane[15]}}, lane[15:0]};
      3'b100:  load_ext = {24'h0, lane[7:0]};
      3'b101:  load_ext = {16'h0, lane[15:0]};
      default: load_ext = lane;
    endcase
  end

  // Store path: per-lane strobe decode; halfwords are known to be 2-byte aligned here.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_strb
      assign lane_strb[gi] = (ctr_reg[1:0] == 2'b10) ||
                             ((ctr_reg[1:0] == 2'b00) && (addr_reg[1:0] == 2'(gi))) ||
                             ((ctr_reg[1:0] == 2'b01) && (addr_reg[1] == 1'(gi / 2)));
    end
  endgenerate

  assign shifted_wdata = wdata_reg << {addr_reg[1:0], 3'b000};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      last_ls_reg  <= 1'b1;
      owner_ls_reg <= 1'b0;
      we_reg       <= 1'b0;
      ctr_reg      <= 3'b000;
      addr_reg     <= 32'h0;
      wdata_reg    <= 32'h0;
      rdata_reg    <= 32'h0;
      err_reg      <= 1'b0;
      cnt_reg      <= 16'h0;
    end else begin
      state_reg    <= state_next;
      last_ls_reg  <= last_ls_next;
      owner_ls_reg <= owner_ls_next;
      we_reg       <= we_next;
      ctr_reg      <= ctr_next;
      addr_reg     <= addr_next;
      wdata_reg    <= wdata_next;
      rdata_reg    <= rdata_next;
      err_reg      <= err_next;
      cnt_reg      <= cnt_next;
    end
  end

  // Next-state and datapath updates
  always_comb begin
    state_next    = state_reg;
    last_ls_next  = last_ls_reg;
    owner_ls_next = owner_ls_reg;
    we_next       = we_reg;
    ctr_next      = ctr_reg;
    addr_next     = addr_reg;
    wdata_next    = wdata_reg;
    rdata_next    = rdata_reg;
    err_next      = err_reg;
    cnt_next      = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (if_win || ls_win) begin
          owner_ls_next = ls_win;
          last_ls_next  = ls_win;
          we_next       = sel_we;
          ctr_next      = sel_ctr;
          addr_next     = sel_addr;
          wdata_next    = sel_wdata;
          rdata_next    = 32'h0;
          cnt_next      = 16'h0;
          if (sel_illegal || sel_misaligned) begin
            err_next   = 1'b1;
            state_next = RESP;
          end else begin
            err_next   = 1'b0;
            state_next = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (bus.mem_ready) state_next = WAIT;
      end
      WAIT: begin
        cnt_next = cnt_inc[15:0];
        // A response in the same cycle as the timeout still counts as success.
        if (bus.mem_rvalid) begin
          rdata_next = we_reg ? 32'h0 : load_ext;
          err_next   = 1'b0;
          state_next = RESP;
        end else if (cnt_inc == 17'(TIMEOUT)) begin
          rdata_next = 32'h0;
          err_next   = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        cnt_next   = 16'h0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    bus.if_gnt    = if_win;
    bus.ls_gnt    = ls_win;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = 32'h0;
    bus.mem_wdata = 32'h0;
    bus.mem_wstrb = 4'b0000;
    bus.if_rvalid = 1'b0;
    bus.if_rdata  = 32'h0;
    bus.if_err    = 1'b0;
    bus.ls_rvalid = 1'b0;
    bus.ls_rdata  = 32'h0;
    bus.ls_err    = 1'b0;
    case (state_reg)
      ISSUE: begin
        bus.mem_req  = 1'b1;
        bus.mem_we   = we_reg;
        bus.mem_addr = {addr_reg[31:2], 2'b00};
        if (we_reg) begin
          bus.mem_wdata = shifted_wdata;
          bus.mem_wstrb = lane_strb;
        end
      end
      RESP: begin
        if (owner_ls_reg) begin
          bus.ls_rvalid = 1'b1;
          bus.ls_rdata  = rdata_reg;
          bus.ls_err    = err_reg;
        end else begin
          bus.if_rvalid = 1'b1;
          bus.if_rdata  = rdata_reg;
          bus.if_err    = err_reg;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: arbitration order, lane handling, error paths,
// timeout and mid-transaction reset, against hand-computed expectations.
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  dmem_arbiter_if bus();

  dmem_arbiter #(.TIMEOUT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Memory model: accepts immediately, answers one cycle later when enabled.
  logic        rv_en = 1'b1;
  logic        rv_q = 1'b0;
  logic [31:0] mem_word = 32'h0;
  assign bus.mem_ready  = bus.mem_req;
  assign bus.mem_rvalid = rv_q;
  assign bus.mem_rdata  = rv_q ? mem_word : 32'h0;
  always @(posedge clk) rv_q <= bus.mem_req & rv_en;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One full transaction; who=0 expects IF to win, who=1 expects LS.
  task automatic txn(input string tag, input bit use_if, input bit use_ls, input bit who,
                     input bit we, input bit [2:0] ctr, input bit [31:0] addr,
                     input bit [31:0] wd, input bit [31:0] word, input bit mem_exp,
                     input bit [3:0] strb_exp, input bit [31:0] wdata_exp,
                     input bit [31:0] rdata_exp, input bit err_exp, input int lat_exp);
    int   lat;
    logic v;
    mem_word = word;
    @(negedge clk);
    bus.if_req   = use_if;
    bus.if_addr  = addr;
    bus.ls_req   = use_ls;
    bus.ls_we    = we;
    bus.ls_ctr   = ctr;
    bus.ls_addr  = addr;
    bus.ls_wdata = wd;
    #1;
    check({tag, ".if_gnt"}, 32'(bus.if_gnt), 32'(use_if && !who));
    check({tag, ".ls_gnt"}, 32'(bus.ls_gnt), 32'(use_ls && who));
    @(negedge clk);
    bus.if_req = 1'b0;
    bus.ls_req = 1'b0;
    #1;
    check({tag, ".mem_req"}, 32'(bus.mem_req), 32'(mem_exp));
    if (mem_exp) begin
      check({tag, ".mem_addr"}, bus.mem_addr, {addr[31:2], 2'b00});
      check({tag, ".mem_we"}, 32'(bus.mem_we), 32'(we));
      check({tag, ".mem_wstrb"}, 32'(bus.mem_wstrb), 32'(strb_exp));
      if (we) check({tag, ".mem_wdata"}, bus.mem_wdata, wdata_exp);
    end
    lat = 1;
    v = who ? bus.ls_rvalid : bus.if_rvalid;
    while (!v && lat < 20) begin
      @(negedge clk);
      #1;
      lat++;
      v = who ? bus.ls_rvalid : bus.if_rvalid;
    end
    check({tag, ".latency"}, 32'(lat), 32'(lat_exp));
    check({tag, ".rdata"}, who ? bus.ls_rdata : bus.if_rdata, rdata_exp);
    check({tag, ".err"}, 32'(who ? bus.ls_err : bus.if_err), 32'(err_exp));
    check({tag, ".other_rvalid"}, 32'(who ? bus.if_rvalid : bus.ls_rvalid), 32'h0);
    $display("txn %s: port=%s lat=%0d rdata=%h err=%0b", tag, who ? "LS" : "IF", lat,
             who ? bus.ls_rdata : bus.if_rdata, who ? bus.ls_err : bus.if_err);
  endtask

  initial begin
    int seen;
    bus.if_req = 1'b0; bus.if_addr = 32'h0;
    bus.ls_req = 1'b0; bus.ls_we = 1'b0; bus.ls_ctr = 3'b000;
    bus.ls_addr = 32'h0; bus.ls_wdata = 32'h0;

    // Reset state, with a request pending that must not be granted
    bus.if_req = 1'b1;
    @(negedge clk);
    #1;
    check("reset.if_gnt", 32'(bus.if_gnt), 32'h0);
    check("reset.mem_req", 32'(bus.mem_req), 32'h0);
    check("reset.if_rvalid", 32'(bus.if_rvalid), 32'h0);
    check("reset.ls_rvalid", 32'(bus.ls_rvalid), 32'h0);
    bus.if_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    //   tag        if ls who we ctr     addr          wdata         word          mem strb     wdata_exp     rdata_exp     err lat
    txn("if_fetch", 1, 0, 0, 0, 3'b010, 32'h8000_0000, 32'h0,        32'h1234_5678, 1, 4'b0000, 32'h0,        32'h1234_5678, 0, 3);

    do_reset();
    txn("tie0",     1, 1, 0, 0, 3'b010, 32'h0000_0100, 32'h0,        32'hCAFE_F00D, 1, 4'b0000, 32'h0,        32'hCAFE_F00D, 0, 3);
    txn("tie1",     1, 1, 1, 0, 3'b010, 32'h0000_0100, 32'h0,        32'hCAFE_F00D, 1, 4'b0000, 32'h0,        32'hCAFE_F00D, 0, 3);
    txn("tie2",     1, 1, 0, 0, 3'b010, 32'h0000_0100, 32'h0,        32'hCAFE_F00D, 1, 4'b0000, 32'h0,        32'hCAFE_F00D, 0, 3);
    txn("tie3",     1, 1, 1, 0, 3'b010, 32'h0000_0100, 32'h0,        32'hCAFE_F00D, 1, 4'b0000, 32'h0,        32'hCAFE_F00D, 0, 3);

    txn("lb",       0, 1, 1, 0, 3'b000, 32'h0000_1003, 32'h0,        32'h80AA_BBCC, 1, 4'b0000, 32'h0,        32'hFFFF_FF80, 0, 3);
    txn("lbu",      0, 1, 1, 0, 3'b100, 32'h0000_1003, 32'h0,        32'h80AA_BBCC, 1, 4'b0000, 32'h0,        32'h0000_0080, 0, 3);
    txn("lh",       0, 1, 1, 0, 3'b001, 32'h0000_1002, 32'h0,        32'h80AA_BBCC, 1, 4'b0000, 32'h0,        32'hFFFF_80AA, 0, 3);
    txn("lhu",      0, 1, 1, 0, 3'b101, 32'h0000_1002, 32'h0,        32'h80AA_BBCC, 1, 4'b0000, 32'h0,        32'h0000_80AA, 0, 3);
    txn("sh",       0, 1, 1, 1, 3'b001, 32'h0000_2002, 32'h0000_BEEF, 32'h5555_5555, 1, 4'b1100, 32'hBEEF_0000, 32'h0,        0, 3);
    txn("sw",       0, 1, 1, 1, 3'b010, 32'h0000_4000, 32'h1122_3344, 32'h5555_5555, 1, 4'b1111, 32'h1122_3344, 32'h0,        0, 3);
    txn("sb",       0, 1, 1, 1, 3'b000, 32'h0000_4001, 32'h0000_00A5, 32'h5555_5555, 1, 4'b0010, 32'h0000_A500, 32'h0,        0, 3);
    txn("lw_misal", 0, 1, 1, 0, 3'b010, 32'h0000_3001, 32'h0,        32'h5555_5555, 0, 4'b0000, 32'h0,        32'h0,        1, 1);
    txn("ctr011",   0, 1, 1, 0, 3'b011, 32'h0000_3000, 32'h0,        32'h5555_5555, 0, 4'b0000, 32'h0,        32'h0,        1, 1);
    txn("st_lbu",   0, 1, 1, 1, 3'b100, 32'h0000_3000, 32'h0000_0011, 32'h5555_5555, 0, 4'b0000, 32'h0,       32'h0,        1, 1);

    // Memory never answers: error 4 cycles after WAIT entry (WAIT entered at T+2)
    rv_en = 1'b0;
    txn("timeout",  0, 1, 1, 0, 3'b010, 32'h0000_5000, 32'h0,        32'h5555_5555, 1, 4'b0000, 32'h0,        32'h0,        1, 6);

    // Reset while in WAIT: transaction abandoned, then a fresh request works
    @(negedge clk);
    bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_ctr = 3'b010; bus.ls_addr = 32'h0000_6000;
    #1;
    check("rstwait.gnt", 32'(bus.ls_gnt), 32'h1);
    @(negedge clk);
    bus.ls_req = 1'b0;
    @(negedge clk);
    bus.ls_req = 1'b1;
    rst_n = 1'b0;
    #1;
    check("rstwait.ls_gnt", 32'(bus.ls_gnt), 32'h0);
    check("rstwait.mem_req", 32'(bus.mem_req), 32'h0);
    check("rstwait.ls_rvalid", 32'(bus.ls_rvalid), 32'h0);
    check("rstwait.if_rvalid", 32'(bus.if_rvalid), 32'h0);
    @(negedge clk);
    bus.ls_req = 1'b0;
    rst_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      #1;
      if (bus.ls_rvalid || bus.if_rvalid || bus.mem_req) seen++;
    end
    check("rstwait.quiet", 32'(seen), 32'h0);
    rv_en = 1'b1;
    txn("after_rst", 0, 1, 1, 0, 3'b010, 32'h0000_7000, 32'h0,       32'hA5A5_0F0F, 1, 4'b0000, 32'h0,        32'hA5A5_0F0F, 0, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
